mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 4096 x 16 `memory` block. It shares the memory between port 0 (CPU fetch/execute path) and port 1 (I/O / loader path). It serialises their read and write requests with round-robin priority and drives the memory's `adress`/`write`/`indata` pins. It returns read data with a one-cycle `ack` pulse per transaction.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port synchronous memory.
// Serialises port 0/1 reads and writes and returns read data with a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] mem_adress,
  output logic          mem_write,
  output logic [DW-1:0] mem_indata,
  input  logic [DW-1:0] mem_outdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StRwait, StDone} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] adress_q, adress_d;
  logic [DW-1:0] indata_q, indata_d;
  logic          write_q, write_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          gnt;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    adress_d = adress_q;
    indata_d = indata_q;
    write_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the port not served last wins; last_q doubles as the current grant.
          gnt      = (req0 && req1) ? ~last_q : req1;
          last_d   = gnt;
          we_d     = gnt ? we1 : we0;
          adress_d = gnt ? addr1 : addr0;
          indata_d = gnt ? wdata1 : wdata0;
          write_d  = gnt ? we1 : we0;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          ack0_d  = ~last_q;
          ack1_d  = last_q;
          state_d = StDone;
        end else begin
          cnt_d   = 3'(READ_LAT);
          state_d = StRwait;
        end
      end
      StRwait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (last_q) rdata1_d = mem_outdata;
          else        rdata0_d = mem_outdata;
          ack0_d  = ~last_q;
          ack1_d  = last_q;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      cnt_q    <= 3'd0;
      adress_q <= '0;
      indata_q <= '0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      adress_q <= adress_d;
      indata_q <= indata_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign busy       = busy_q;
  assign mem_adress = adress_q;
  assign mem_write  = write_q;
  assign mem_indata = indata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random bench for mem_arbiter with a behavioural 4096 x 16 memory
// and a per-port scoreboard of expected completions.
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned RL = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_write;
  logic [DW-1:0] rdata0, rdata1, mem_indata;
  logic [AW-1:0] mem_adress;
  logic [DW-1:0] mem_outdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(RL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .busy       (busy),
    .mem_adress (mem_adress),
    .mem_write  (mem_write),
    .mem_indata (mem_indata),
    .mem_outdata(mem_outdata)
  );

  // Behavioural synchronous memory, one cycle read latency.
  logic [DW-1:0] mem_array [4096] = '{default: '0};
  always @(posedge clk) begin
    if (mem_write) mem_array[mem_adress] <= mem_indata;
    mem_outdata <= mem_array[mem_adress];
  end

  typedef struct packed {
    logic          is_wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp0[$], exp1[$];
  int            ack_log[$];
  logic [DW-1:0] model_mem [4096];
  logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
  int            n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle, sample just after the edge, and retire any completions.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp0.delete();
      exp1.delete();
      last_rd0 = '0;
      last_rd1 = '0;
    end else begin
      if (ack0 || ack1) chk("ack_overlap", 32'(ack0 & ack1), 32'd0);
      if (ack0) begin
        chk("ack0_pending", 32'(exp0.size() != 0), 32'd1);
        if (exp0.size() != 0) begin
          e = exp0.pop_front();
          if (e.is_wr) chk("wr0_rdata_held", 32'(rdata0), 32'(last_rd0));
          else begin
            chk("rd0_data", 32'(rdata0), 32'(e.data));
            last_rd0 = e.data;
          end
        end
        chk("rdata1_untouched", 32'(rdata1), 32'(last_rd1));
        ack_log.push_back(0);
      end
      if (ack1) begin
        chk("ack1_pending", 32'(exp1.size() != 0), 32'd1);
        if (exp1.size() != 0) begin
          e = exp1.pop_front();
          if (e.is_wr) chk("wr1_rdata_held", 32'(rdata1), 32'(last_rd1));
          else begin
            chk("rd1_data", 32'(rdata1), 32'(e.data));
            last_rd1 = e.data;
          end
        end
        chk("rdata0_untouched", 32'(rdata0), 32'(last_rd0));
        ack_log.push_back(1);
      end
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    exp_t e;
    e.is_wr = we;
    e.data  = we ? '0 : model_mem[a];
    if (we) model_mem[a] = d;
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      exp0.push_back(e);
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      exp1.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
      tick();
      n++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    chk("drain_done", 32'(exp0.size() + exp1.size()), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    exp0.delete();
    exp1.delete();
  endtask

  task automatic op(input int p, input logic we, input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    issue(p, we, a, d);
    drain(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1, n, ops, mode;
    logic [AW-1:0] a, b;

    for (int i = 0; i < 4096; i++) model_mem[i] = '0;

    // Reset with both ports requesting.
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (3) tick();
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    chk("rst_mem_adress", 32'(mem_adress), 32'd0);
    chk("rst_mem_indata", 32'(mem_indata), 32'd0);
    issue(0, 1'b0, 12'h010, '0);
    issue(1, 1'b0, 12'h020, '0);
    ack_log.delete();
    rst_n = 1'b1;
    drain(40);
    chk("rst_grant_count", 32'(ack_log.size()), 32'd2);
    chk("rst_first_grant", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'hFF, 32'd0);
    tick();

    // Single write on port 0 with cycle-exact strobe and ack.
    issue(0, 1'b1, 12'h123, 16'hBEEF);
    tick();
    chk("wr_strobe", 32'(mem_write), 32'd1);
    chk("wr_adress", 32'(mem_adress), 32'h123);
    chk("wr_indata", 32'(mem_indata), 32'hBEEF);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_no_early_ack", 32'(ack0), 32'd0);
    tick();
    chk("wr_strobe_one_cycle", 32'(mem_write), 32'd0);
    chk("wr_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    tick();
    chk("wr_ack0_pulse", 32'(ack0), 32'd0);
    chk("wr_idle", 32'(busy), 32'd0);

    // Read back on port 0.
    issue(0, 1'b0, 12'h123, '0);
    tick();
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_no_strobe", 32'(mem_write), 32'd0);
    chk("rd_adress", 32'(mem_adress), 32'h123);
    tick();
    chk("rd_no_early_ack", 32'(ack0), 32'd0);
    tick();
    chk("rd_ack0", 32'(ack0), 32'd1);
    chk("rd_rdata0", 32'(rdata0), 32'hBEEF);
    chk("rd_rdata1_unchanged", 32'(rdata1), 32'd0);
    req0 = 1'b0;
    tick();

    op(1, 1'b0, 12'h123, '0);
    tick();

    // Contention: port 0 reads, port 1 writes, both held.
    ack_log.delete();
    c0 = 0; c1 = 0; n = 0;
    issue(0, 1'b0, 12'h120, '0);
    issue(1, 1'b1, 12'h300, 16'h1000);
    while ((c0 < 4 || c1 < 4) && n < 200) begin
      tick();
      n++;
      if (ack0) begin
        c0++;
        if (c0 < 4) issue(0, 1'b0, 12'h120 + 12'(c0), '0);
        else req0 = 1'b0;
      end
      if (ack1) begin
        c1++;
        if (c1 < 4) issue(1, 1'b1, 12'h300 + 12'(c1), 16'h1000 + 16'(c1));
        else req1 = 1'b0;
      end
    end
    chk("cont_acks0", 32'(c0), 32'd4);
    chk("cont_acks1", 32'(c1), 32'd4);
    chk("cont_grant_count", 32'(ack_log.size()), 32'd8);
    foreach (ack_log[i]) chk("cont_alternate", 32'(ack_log[i]), 32'(i % 2));
    exp0.delete();
    exp1.delete();
    tick();

    // Late arrival of port 1 during a port 0 read.
    op(1, 1'b1, 12'h456, 16'h4567);
    tick();
    issue(0, 1'b0, 12'h123, '0);
    tick();
    tick();
    issue(1, 1'b0, 12'h456, '0);
    tick();
    chk("late_ack0", 32'(ack0), 32'd1);
    chk("late_adress_hold", 32'(mem_adress), 32'h123);
    req0 = 1'b0;
    tick();
    chk("late_idle", 32'(busy), 32'd0);
    chk("late_adress_idle", 32'(mem_adress), 32'h123);
    tick();
    chk("late_accept", 32'(busy), 32'd1);
    chk("late_adress1", 32'(mem_adress), 32'h456);
    drain(20);
    tick();

    // Reset in the middle of a read.
    issue(0, 1'b0, 12'h123, '0);
    tick();
    tick();
    rst_n = 1'b0;
    req0  = 1'b0;
    tick();
    chk("mid_rst_ack0", 32'(ack0), 32'd0);
    chk("mid_rst_rdata0", 32'(rdata0), 32'd0);
    chk("mid_rst_rdata1", 32'(rdata1), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_strobe", 32'(mem_write), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_no_ack0", 32'(ack0), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    op(0, 1'b0, 12'h123, '0);

    // Full sweep: port 1 writes address, port 0 reads back.
    for (int i = 0; i < 4096; i++) op(1, 1'b1, 12'(i), 16'(i));
    for (int i = 0; i < 4096; i++) op(0, 1'b0, 12'(i), '0);

    // Random mixed traffic, concurrent ops target distinct addresses.
    ops = 0;
    while (ops < 2000) begin
      mode = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 63));
      if (mode == 2) begin
        b = a ^ 12'($urandom_range(1, 63));
        issue(0, 1'($urandom_range(0, 1)), a, 16'($urandom));
        issue(1, 1'($urandom_range(0, 1)), b, 16'($urandom));
        drain(30);
        ops += 2;
      end else begin
        op(mode, 1'($urandom_range(0, 1)), a, 16'($urandom));
        ops++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
